// File: rtl/key_event.sv
// Key gesture decoder: turns a debounced key level into short/double/long/repeat pulses.
// One shared down-stream counter times the long hold, the double-click gap and the repeat period.
module key_event #(
  parameter int LONG_CNT   = 50_000_000,
  parameter int DCLICK_CNT = 15_000_000,
  parameter int REPEAT_CNT = 5_000_000,
  parameter int CNT_W      = 26
) (
  input  logic clk,
  input  logic rst,
  input  logic key_state,
  output logic key_down,
  output logic short_press,
  output logic double_click,
  output logic long_press,
  output logic key_repeat
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PRESS1 = 3'd1,
    WAIT2  = 3'd2,
    PRESS2 = 3'd3,
    LONG   = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] LONG_TC   = CNT_W'(LONG_CNT - 1);
  localparam logic [CNT_W-1:0] DCLICK_TC = CNT_W'(DCLICK_CNT - 1);
  localparam logic [CNT_W-1:0] REPEAT_TC = CNT_W'(REPEAT_CNT - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             key_d_q, key_d_d;
  logic             key_down_q, key_down_d;
  logic             short_press_q, short_press_d;
  logic             double_click_q, double_click_d;
  logic             long_press_q, long_press_d;
  logic             key_repeat_q, key_repeat_d;
  logic             press_edge, release_edge;

  assign press_edge   = key_d_q & ~key_state;
  assign release_edge = ~key_d_q & key_state;

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    key_d_d        = key_state;
    key_down_d     = ~key_state;
    short_press_d  = 1'b0;
    double_click_d = 1'b0;
    long_press_d   = 1'b0;
    key_repeat_d   = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (press_edge) state_d = PRESS1;
      end
      PRESS1: begin
        // a release on the terminal cycle still counts as a short press
        if (release_edge) begin
          state_d = WAIT2;
          cnt_d   = '0;
        end else if (cnt_q == LONG_TC) begin
          state_d      = LONG;
          cnt_d        = '0;
          long_press_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      WAIT2: begin
        if (press_edge) begin
          state_d = PRESS2;
          cnt_d   = '0;
        end else if (cnt_q == DCLICK_TC) begin
          state_d       = IDLE;
          cnt_d         = '0;
          short_press_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      PRESS2: begin
        cnt_d = '0;
        if (release_edge) begin
          state_d        = IDLE;
          double_click_d = 1'b1;
        end
      end
      LONG: begin
        if (release_edge) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == REPEAT_TC) begin
          cnt_d        = '0;
          key_repeat_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      key_d_q        <= 1'b1;
      key_down_q     <= 1'b0;
      short_press_q  <= 1'b0;
      double_click_q <= 1'b0;
      long_press_q   <= 1'b0;
      key_repeat_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      key_d_q        <= key_d_d;
      key_down_q     <= key_down_d;
      short_press_q  <= short_press_d;
      double_click_q <= double_click_d;
      long_press_q   <= long_press_d;
      key_repeat_q   <= key_repeat_d;
    end
  end

  assign key_down     = key_down_q;
  assign short_press  = short_press_q;
  assign double_click = double_click_q;
  assign long_press   = long_press_q;
  assign key_repeat   = key_repeat_q;

endmodule

// File: doc/key_event.md
KEY_EVENT -- requirements
Module: key_event

Interface
REQ-001 SHALL provide parameter LONG_CNT, default 50_000_000, hold cycles before long_press (1 s at 50 MHz).
REQ-002 SHALL provide parameter DCLICK_CNT, default 15_000_000, maximum release gap in cycles for a double click (300 ms).
REQ-003 SHALL provide parameter REPEAT_CNT, default 5_000_000, cycles between key_repeat pulses (100 ms).
REQ-004 SHALL provide parameter CNT_W, default 26, counter width; every *_CNT SHALL be >= 2 and < 2^CNT_W.
REQ-005 SHALL use one clock and a synchronous, active-high reset, per the ports below.
REQ-006 clk  input  1  system clock, 50 MHz; all logic on the rising edge.
REQ-007 rst  input  1  synchronous reset, active-high.
REQ-008 key_state  input  1  debounced key level from the key debouncer, clk-synchronous; 1 = released, 0 = pressed.
REQ-009 key_down  output  1  registered level; 1 while the key is pressed.
REQ-010 short_press  output  1  one-cycle pulse for a single press-release not followed by a second press.
REQ-011 double_click  output  1  one-cycle pulse for two presses within the DCLICK_CNT gap.
REQ-012 long_press  output  1  one-cycle pulse when a first press is held for LONG_CNT cycles.
REQ-013 key_repeat  output  1  one-cycle pulse every REPEAT_CNT cycles while a long press is held.

Function
REQ-014 SHALL hold a one-cycle delayed copy key_d of key_state.
- press edge = key_d=1 and key_state=0.
- release edge = key_d=0 and key_state=1.
REQ-015 key_down SHALL equal ~key_state, delayed by one register.
REQ-016 SHALL implement the FSM states IDLE, PRESS1, WAIT2, PRESS2 and LONG, with one counter cnt of width CNT_W.
REQ-017 IDLE: on a press edge, go to PRESS1 with cnt=0.
REQ-018 PRESS1 while pressed: cnt increments each cycle.
- At cnt=LONG_CNT-1, go to LONG with cnt=0.
- long_press is high for exactly one cycle, LONG_CNT cycles after the edge that first sampled key_state=0.
REQ-019 PRESS1 on a release edge before the LONG transition: go to WAIT2 with cnt=0.
REQ-020 WAIT2 on a press edge: go to PRESS2.
REQ-021 WAIT2 otherwise: cnt increments.
- At cnt=DCLICK_CNT-1, pulse short_press once and go to IDLE.
- If a press edge and the timeout fall in the same cycle, the press edge wins: go to PRESS2, no short_press.
REQ-022 PRESS2 on a release edge: pulse double_click once and go to IDLE, regardless of hold length; PRESS2 SHALL NOT generate long_press.
REQ-023 LONG while pressed: cnt increments.
- At cnt=REPEAT_CNT-1, pulse key_repeat and reload cnt=0.
- The first key_repeat comes REPEAT_CNT cycles after long_press.
REQ-024 LONG on a release edge: go to IDLE with no further pulse; short_press SHALL NOT follow a long press.
REQ-025 All event outputs SHALL be registered, and at most one event output SHALL be high in any cycle.
REQ-026 Counters SHALL never wrap; each state leaves or reloads before cnt reaches its terminal value + 1.

Reset
REQ-027 While rst=1 at a clock edge, the next state SHALL be:
- state IDLE, cnt=0, key_d=1;
- key_down=0, short_press=0, double_click=0, long_press=0, key_repeat=0.
REQ-028 rst asserted mid-operation (any state) SHALL discard the pending event; no pulse is emitted for it afterwards.
REQ-029 A key held through rst deassertion SHALL be treated as a new press: press edge on the first post-reset cycle, then normal PRESS1 behaviour.

Verification (LONG_CNT=100, DCLICK_CNT=30, REPEAT_CNT=20)
REQ-030 Press 10 cycles, release, idle -> single short_press pulse 30 cycles after release sampled; no other pulses.
REQ-031 Press 10, release 10, press 10, release -> one double_click on the cycle after the second release sampled; no short_press.
REQ-032 Hold 150 cycles -> long_press at cycle 100, key_repeat at cycles 120 and 140; on release no pulse; key_down high exactly while held (+1 cycle lag).
REQ-033 Release gap boundary: second press sampled at WAIT2 cnt=29 -> double_click on its release, no short_press; gap of 31 cycles -> short_press, then the second press is a fresh PRESS1.
REQ-034 rst pulsed 1 cycle during WAIT2 -> all outputs 0, no short_press ever for that press.
REQ-035 key_state=0 throughout reset, held 100 cycles after deassert -> long_press exactly 100 cycles after the first post-reset edge.
